// File: rtl/dram_axi_pkg.sv
// Shared types and default widths for the DRAM AXI slave memory model.
package dram_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  localparam int DRAM_ADDR_W = 16;
  localparam int DRAM_DATA_W = 16;

endpackage

// File: rtl/dram_rd_fifo.sv
// Synchronous FIFO holding accepted read addresses; head is the entry being served.
module dram_rd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dram_axi_slv_mem.sv
// DRAM AXI slave memory model: buffered AW/W commit with B response, and an
// in-order read queue served with a fixed access latency.
module dram_axi_slv_mem
  import dram_axi_pkg::*;
#(
  parameter int ADDR_W   = DRAM_ADDR_W,
  parameter int DATA_W   = DRAM_DATA_W,
  parameter int DEPTH    = 1024,
  parameter int RD_LAT   = 4,
  parameter int RQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              bvalid,
  output logic [1:0]        bresp,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int RQ_CW = $clog2(RQ_DEPTH) + 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < LIMIT);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_full;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_full;
  logic [DATA_W-1:0] w_data;
  logic              commit;
  resp_t             bresp_q;

  logic              rq_full;
  logic              rq_empty;
  logic [RQ_CW-1:0]  rq_count;
  logic [ADDR_W-1:0] rq_head;
  logic              ar_push;
  logic              r_pop;
  logic              promote;
  logic              lat_busy;
  logic [LAT_W-1:0]  lat_cnt;
  resp_t             rresp_q;

  assign awready = !aw_full;
  assign wready  = !w_full;
  assign commit  = aw_full && w_full && !bvalid;
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      bvalid  <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      if (awvalid && !aw_full) begin
        aw_full <= 1'b1;
        aw_addr <= awaddr;
      end
      if (wvalid && !w_full) begin
        w_full <= 1'b1;
        w_data <= wdata;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      // Commit only fires with both buffers full, so it never races an acceptance.
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp_q <= in_range(aw_addr) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && commit && in_range(aw_addr)) mem[aw_addr[IDX_W-1:0]] <= w_data;
  end

  assign arready = !rq_full;
  assign ar_push = arvalid && arready;
  assign r_pop   = rvalid && rready;
  assign promote = (ar_push && rq_empty) || (r_pop && ((rq_count > RQ_CW'(1)) || ar_push));

  dram_rd_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (RQ_DEPTH)
  ) u_rd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ar_push),
    .push_data (araddr),
    .pop       (r_pop),
    .full      (rq_full),
    .empty     (rq_empty),
    .count     (rq_count),
    .head      (rq_head)
  );

  // Capture reads mem with the pre-edge contents, so a same-edge commit is not seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_busy <= 1'b0;
      lat_cnt  <= '0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      if (r_pop) rvalid <= 1'b0;
      if (promote) begin
        lat_busy <= 1'b1;
        lat_cnt  <= LAT_W'(RD_LAT - 1);
      end else if (lat_busy) begin
        if (lat_cnt == '0) begin
          lat_busy <= 1'b0;
          rvalid   <= 1'b1;
          rdata    <= in_range(rq_head) ? mem[rq_head[IDX_W-1:0]] : '0;
          rresp_q  <= in_range(rq_head) ? RESP_OKAY : RESP_SLVERR;
        end else begin
          lat_cnt <= lat_cnt - LAT_W'(1);
        end
      end
    end
  end

endmodule
